// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder receive path.
package spi_pkg;

    // SPI mode 0: SCLK idles low, data is sampled on the rising edge.
    localparam logic Cpol = 1'b0;
    localparam logic Cpha = 1'b0;

    typedef enum logic [1:0] {
        OpHold  = 2'b00,
        OpShift = 2'b01,
        OpClear = 2'b10
    } sipo_op_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } rx_state_e;

endpackage

// File: rtl/spi_slave_rx_sipo.sv
// Serial-in/parallel-out register, MSB first; mirrors the transmit-side PISO.
module sipo_reg
    import spi_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             din_i,
    input  logic [1:0]       op_i,
    output logic [Width-1:0] dout_o
);

    logic [Width-1:0] sr_d, sr_q;

    always_comb begin
        sr_d = sr_q;
        case (op_i)
            OpShift: sr_d = {sr_q[Width-2:0], din_i};
            OpClear: sr_d = '0;
            default: sr_d = sr_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout_o = sr_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder receiver: oversampled pins, word assembly, valid and framing-error pulses.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned Width      = 8,
    parameter int unsigned SyncStages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sclk_i,
    input  logic             cs_ni,
    input  logic             mosi_i,
    output logic [Width-1:0] dout_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             frm_err_o
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);

    logic [SyncStages-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, primed_q;
    logic                  sclk_prev_q;
    logic                  sclk_s, cs_s, mosi_s, primed, sample;

    rx_state_e        state_d, state_q;
    logic [CntW-1:0]  cnt_d, cnt_q;
    logic [Width-1:0] dout_d, dout_q;
    logic             valid_d, valid_q;
    logic             err_d, err_q;
    logic             armed_d, armed_q;
    logic [1:0]       sr_op;
    logic [Width-1:0] sr;
    logic [Width-1:0] word;

    assign sclk_s = sclk_sync_q[SyncStages-1];
    assign cs_s   = cs_sync_q[SyncStages-1];
    assign mosi_s = mosi_sync_q[SyncStages-1];
    // Synced CS only reflects the pin once the chain has refilled after reset.
    assign primed = primed_q[SyncStages-1];
    assign sample = (sclk_s ^ sclk_prev_q) & (sclk_s ^ Cpol ^ Cpha);
    assign word   = {sr[Width-2:0], mosi_s};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        armed_d = armed_q;
        sr_op   = OpHold;
        unique case (state_q)
            StIdle: begin
                sr_op = OpClear;
                cnt_d = '0;
                if (primed && cs_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !cs_s) begin
                    state_d = StShift;
                    armed_d = 1'b0;
                end
            end
            StShift: begin
                if (sample) begin
                    sr_op = OpShift;
                    if (cnt_q == LastBit) begin
                        dout_d  = word;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (cs_s) begin
                    // A rise in the same cycle is counted before the partial-word check.
                    err_d   = sample ? (cnt_q != LastBit) : (cnt_q != '0);
                    state_d = StIdle;
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sclk_sync_q <= {SyncStages{Cpol}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            primed_q    <= '0;
            sclk_prev_q <= Cpol;
            state_q     <= StIdle;
            cnt_q       <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SyncStages-2:0], cs_ni};
            mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi_i};
            primed_q    <= {primed_q[SyncStages-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            armed_q     <= armed_d;
        end
    end

    sipo_reg #(
        .Width (Width)
    ) u_sipo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .din_i  (mosi_s),
        .op_i   (sr_op),
        .dout_o (sr)
    );

    assign dout_o    = dout_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q == StShift);
    assign frm_err_o = err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: SCLK = clk/8, mode 0, Width = 8.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] dout;
    logic       valid, busy, frm_err;

    int tests = 0;
    int fails = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    int cyc = 0;
    logic [7:0] wq[$];
    int tq[$];

    always #5 clk = ~clk;

    spi_slave_rx #(
        .Width      (8),
        .SyncStages (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .sclk_i    (sclk),
        .cs_ni     (cs_n),
        .mosi_i    (mosi),
        .dout_o    (dout),
        .valid_o   (valid),
        .busy_o    (busy),
        .frm_err_o (frm_err)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid) begin
            vcnt <= vcnt + 1;
            wq.push_back(dout);
            tq.push_back(cyc);
        end
        if (frm_err) ecnt <= ecnt + 1;
        if (valid && frm_err) both <= both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        cycles(4);
        sclk = 1'b1;
        cycles(4);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(data[i]);
    endtask

    task automatic frame(input logic [31:0] data, input int n);
        cs_n = 1'b0;
        cycles(4);
        send_bits(data, n);
        cycles(4);
        cs_n = 1'b1;
        cycles(8);
    endtask

    initial begin
        int v0, e0, n0;

        // Reset and idle
        cycles(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {dout, valid, busy, frm_err}, 32'h0);
        end
        cycles(1);

        // Single frame 0xA5 with busy timing
        v0 = vcnt; e0 = ecnt; n0 = wq.size();
        cs_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_rise_early", busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("busy_rise", busy, 1'b1);
        cycles(1);
        send_bits(32'hA5, 8);
        cycles(4);
        cs_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_fall_early", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("busy_fall", busy, 1'b0);
        cycles(6);
        check("a5_valid_count", vcnt - v0, 1);
        check("a5_word", (wq.size() > n0) ? wq[n0] : 8'hxx, 8'hA5);
        check("a5_dout_hold", dout, 8'hA5);
        check("a5_no_err", ecnt - e0, 0);

        // Back-to-back 0x3C, 0xFF in one frame
        v0 = vcnt; n0 = wq.size();
        frame(32'h3CFF, 16);
        check("b2b_valid_count", vcnt - v0, 2);
        check("b2b_word0", (wq.size() > n0) ? wq[n0] : 8'hxx, 8'h3C);
        check("b2b_word1", (wq.size() > n0 + 1) ? wq[n0+1] : 8'hxx, 8'hFF);
        check("b2b_spacing", (tq.size() > n0 + 1) ? tq[n0+1] - tq[n0] : -1, 64);

        // Partial frame: 5 bits of 0x81, then 0x0F
        v0 = vcnt; e0 = ecnt;
        frame(32'h10, 5);
        check("partial_err", ecnt - e0, 1);
        check("partial_no_valid", vcnt - v0, 0);
        check("partial_dout_kept", dout, 8'hFF);
        n0 = wq.size();
        frame(32'h0F, 8);
        check("after_partial_word", (wq.size() > n0) ? wq[n0] : 8'hxx, 8'h0F);

        // Last rise and CS deassert reach the sync outputs together
        v0 = vcnt; e0 = ecnt; n0 = wq.size();
        cs_n = 1'b0;
        cycles(4);
        send_bits(32'h61, 7);
        mosi = 1'b1;
        cycles(4);
        sclk = 1'b1;
        cs_n = 1'b1;
        cycles(4);
        sclk = 1'b0;
        cycles(8);
        check("simul_valid", vcnt - v0, 1);
        check("simul_no_err", ecnt - e0, 0);
        check("simul_word", (wq.size() > n0) ? wq[n0] : 8'hxx, 8'hC3);

        // Reset mid-frame with CS held low
        cs_n = 1'b0;
        cycles(4);
        send_bits(32'hA, 4);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_outputs", {dout, valid, busy, frm_err}, 32'h0);
        v0 = vcnt; e0 = ecnt;
        cycles(1);
        send_bits(32'hBEE, 12);
        check("rst_ignored_busy", busy, 1'b0);
        check("rst_ignored_valid", vcnt - v0, 0);
        cycles(4);
        cs_n = 1'b1;
        cycles(8);
        send_bits(32'hFF, 8);
        cycles(4);
        check("cs_high_no_valid", vcnt - v0, 0);
        check("rst_no_err", ecnt - e0, 0);
        n0 = wq.size();
        frame(32'h5A, 8);
        check("post_rst_word", (wq.size() > n0) ? wq[n0] : 8'hxx, 8'h5A);
        check("post_rst_dout", dout, 8'h5A);
        check("never_both", both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI responder-side receiver; the counterpart of the write-path transmitter. It samples MOSI on SCLK rising edges (mode 0: CPOL=0, CPHA=0, MSB first) while CS is low, and assembles Width-bit words in a serial-in/parallel-out register. Each completed word is presented on a parallel output with a one-cycle valid strobe. SPI pins are asynchronous to clk_i and are oversampled; clk_i must be at least 4x the SCLK frequency.

Parameters:
Width, 8, word length in bits (>=2)
SyncStages, 2, flip-flop stages per synchronized SPI input (>=2)

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_ni  input  1  synchronous active-low reset
sclk_i  input  1  SPI serial clock, asynchronous
cs_ni  input  1  SPI chip select, active low, asynchronous
mosi_i  input  1  SPI serial data in, asynchronous
dout_o  output  Width  last completed word
valid_o  output  1  one-cycle pulse: dout_o updated this cycle
busy_o  output  1  high while a frame is active (synchronized CS low)
frm_err_o  output  1  one-cycle pulse: CS deasserted with a partial word

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): sync chains load idle values (sclk=0, cs=1, mosi=0); dout_o=0, valid_o=0, busy_o=0, frm_err_o=0; bit counter=0; shift register=0; FSM=IDLE.
- Synchronization: sclk_i, cs_ni and mosi_i each pass through SyncStages flops. Edge detect uses one extra flop on synced sclk: rise = synced & ~prev. Latency from a pin transition to the internal rise/CS event is SyncStages+1 clk_i cycles. mosi shares the same delay, so the sampled bit is the value present at the SCLK edge.
- FSM states: IDLE, SHIFT.
  - IDLE: busy_o=0; bit counter and shift register held cleared. Synced cs=0 -> SHIFT.
  - SHIFT: busy_o=1. On each rise: shift register takes {sr[Width-2:0], mosi_sync}; counter increments.
    - When the rise brings the counter to Width, the completed word {sr[Width-2:0], mosi_sync} loads into dout_o on that same edge. valid_o=1 for exactly that cycle. Counter wraps to 0 and SHIFT continues for the next word (back-to-back words in one frame).
    - Synced cs=1 -> IDLE. If counter!=0 at that moment, pulse frm_err_o for one cycle and discard the partial word; dout_o is unchanged.
- Simultaneous events: a rise and a CS deassert in the same cycle. The rise is processed first. If that rise completes a word, valid_o pulses and frm_err_o does not. Otherwise the bit is counted and frm_err_o pulses.
- Rises while synced cs=1 are ignored. Falling SCLK edges are ignored.
- dout_o holds its value until the next completed word or reset. There is no backpressure: a consumer must capture dout_o on valid_o.
- Reset mid-frame: all state returns to reset values immediately. The frame resumes only after CS is observed high and then low again. After reset, the FSM needs synced cs=1 in IDLE before accepting a new CS-low; a frame already in progress at reset release is ignored until CS is toggled.
- busy_o is registered from the FSM state.
- valid_o and frm_err_o are registered and never assert in the same cycle.

Decomposition:
- Shared package spi_pkg:
  - SIPO op encodings: OP_HOLD=2'b00, OP_SHIFT=2'b01, OP_CLEAR=2'b10 (2'b11 treated as HOLD).
  - FSM state encodings: ST_IDLE, ST_SHIFT.
  - Mode constant: CPOL=0, CPHA=0.
- Sub-module sipo_reg (parameter Width; ports clk_i, rst_ni, din_i, op_i, dout_o[Width-1:0]): left-shift serial-in register, the mirror of the transmit-side PISO.
- Synchronizer chains, edge detect, counter and FSM live in spi_slave_rx.

Test Plan:
- Reset, then cs_ni=1 with sclk idle -> dout_o=0, valid_o, busy_o and frm_err_o all 0 for 20 cycles.
- One frame of 8'hA5, SCLK = clk/8 -> valid_o pulses once, dout_o=8'hA5 starting that cycle, busy_o high from CS-low+3 cycles to CS-high+3 cycles, frm_err_o never asserts.
- Back-to-back 8'h3C then 8'hFF in one CS frame -> two valid_o pulses 8 SCLK periods apart, with dout_o=8'h3C then 8'hFF.
- CS raised after 5 bits of 8'h81 -> frm_err_o pulses once, no valid_o, dout_o keeps its prior value. The next full frame of 8'h0F yields dout_o=8'h0F.
- Last (8th) rising edge and CS deassert arrive at the synchronized inputs in the same cycle -> valid_o=1, frm_err_o=0, word captured correctly.
- rst_ni pulsed low after 4 bits, CS still low -> outputs cleared, no valid_o until CS toggles high then low. A subsequent 8'h5A frame is received correctly. SCLK edges while cs_ni=1 produce no valid_o.
